// File: rtl/execute_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execute_stage_pkg : shared EX-stage encodings, EX/MEM record, forward mux.
// Rev 1.0
// ----------------------------------------------------------------------------
package execute_stage_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
  } exmem_t;

  // Reserved select code 11 falls back to the register-file operand.
  function automatic logic [31:0] fwd_select(
    input logic [1:0]  sel,
    input logic [31:0] rf_val,
    input logic [31:0] wb_val,
    input logic [31:0] mem_val
  );
    logic [31:0] val;
    case (sel)
      FWD_RF:  val = rf_val;
      FWD_WB:  val = wb_val;
      FWD_MEM: val = mem_val;
      default: val = rf_val;
    endcase
    return val;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execute_stage_if : ID/EX inputs, forwarding/control and EX/MEM outputs.
// Rev 1.0
// ----------------------------------------------------------------------------
interface execute_stage_if;

  logic        RegWriteE;
  logic        MemWriteE;
  logic        JumpE;
  logic        BranchE;
  logic        ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [4:0]  RdE;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] ImmExtE;
  logic [31:0] PCE;
  logic [31:0] PCPlus4E;

  logic [1:0]  ForwardAE;
  logic [1:0]  ForwardBE;
  logic [31:0] ResultW;
  logic        StallM;
  logic        FlushM;

  logic        PCSrcE;
  logic [31:0] PCTargetE;

  logic        RegWriteM;
  logic        MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [31:0] PCPlus4M;

  modport master (
    output RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    input  PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );

  modport slave (
    input  RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE,
           ALUControlE, RdE, RD1_E, RD2_E, ImmExtE, PCE, PCPlus4E,
           ForwardAE, ForwardBE, ResultW, StallM, FlushM,
    output PCSrcE, PCTargetE, RegWriteM, MemWriteM, ResultSrcM, RdM,
           ALUResultM, WriteDataM, PCPlus4M
  );

endinterface
`default_nettype wire

// File: rtl/execute_stage_alu.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu : 32-bit add/sub/and/or/signed-slt with zero flag.
// Rev 1.0
// ----------------------------------------------------------------------------
module alu
  import execute_stage_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  ALUControl,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'd0;
    case (ALUControl)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule
`default_nettype wire

// File: rtl/execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// execute_stage : operand forwarding, ALU, branch resolve and EX/MEM register.
// Rev 1.0
// ----------------------------------------------------------------------------
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  execute_stage_if.slave ex
);

  logic [31:0] src_a;
  logic [31:0] src_b_fwd;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        alu_zero;
  exmem_t      exmem_d;
  exmem_t      exmem_q;

  // Forwarding from MEM uses the registered result, so back-to-back deps resolve.
  always_comb begin
    src_a     = fwd_select(ex.ForwardAE, ex.RD1_E, ex.ResultW, exmem_q.alu_result);
    src_b_fwd = fwd_select(ex.ForwardBE, ex.RD2_E, ex.ResultW, exmem_q.alu_result);
    src_b     = ex.ALUSrcE ? ex.ImmExtE : src_b_fwd;
  end

  alu u_alu (
    .a          (src_a),
    .b          (src_b),
    .ALUControl (ex.ALUControlE),
    .result     (alu_result),
    .zero       (alu_zero)
  );

  assign ex.PCSrcE    = (ex.BranchE & alu_zero) | ex.JumpE;
  assign ex.PCTargetE = ex.PCE + ex.ImmExtE;

  always_comb begin
    exmem_d            = '0;
    exmem_d.reg_write  = ex.RegWriteE;
    exmem_d.mem_write  = ex.MemWriteE;
    exmem_d.result_src = ex.ResultSrcE;
    exmem_d.rd         = ex.RdE;
    exmem_d.alu_result = alu_result;
    exmem_d.write_data = src_b_fwd;
    exmem_d.pc_plus4   = ex.PCPlus4E;
  end

  // Flush beats stall; reset beats both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exmem_q <= '0;
    end else if (ex.FlushM) begin
      exmem_q <= '0;
    end else if (!ex.StallM) begin
      exmem_q <= exmem_d;
    end
  end

  assign ex.RegWriteM  = exmem_q.reg_write;
  assign ex.MemWriteM  = exmem_q.mem_write;
  assign ex.ResultSrcM = exmem_q.result_src;
  assign ex.RdM        = exmem_q.rd;
  assign ex.ALUResultM = exmem_q.alu_result;
  assign ex.WriteDataM = exmem_q.write_data;
  assign ex.PCPlus4M   = exmem_q.pc_plus4;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_execute_stage : scoreboard bench with directed and random stimulus.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_execute_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  execute_stage_if ifc ();

  execute_stage dut (
    .clk (clk),
    .rst (rst),
    .ex  (ifc.slave)
  );

  typedef struct {
    logic        rst, regwrite, memwrite, jump, branch, alusrc, stall, flush;
    logic [1:0]  resultsrc, fa, fb;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [31:0] rd1, rd2, imm, pc, pc4, resw;
  } stim_t;

  typedef struct {
    logic        regwrite, memwrite;
    logic [1:0]  resultsrc;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exm_t;

  typedef struct {
    logic        pcsrc;
    logic [31:0] target;
  } comb_t;

  exm_t  reg_q[$];
  comb_t comb_q[$];
  exm_t  m;
  event  comb_ev;
  int    pass_cnt = 0;
  int    total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  // Reference behaviour written straight from the operation table.
  function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf,
                                       input logic [31:0] wb, input logic [31:0] mem);
    if (sel == 2'd1) return wb;
    if (sel == 2'd2) return mem;
    return rf;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst = ($urandom_range(39) == 0);
    s.regwrite = 1'($urandom); s.memwrite = 1'($urandom);
    s.jump = ($urandom_range(5) == 0); s.branch = 1'($urandom);
    s.alusrc = 1'($urandom);
    s.stall = ($urandom_range(4) == 0); s.flush = ($urandom_range(9) == 0);
    s.resultsrc = 2'($urandom); s.fa = 2'($urandom); s.fb = 2'($urandom);
    s.op = 3'($urandom); s.rd = 5'($urandom);
    s.rd1 = $urandom; s.rd2 = $urandom;
    if ($urandom_range(3) == 0) s.rd2 = s.rd1;
    if ($urandom_range(3) == 0) begin s.rd1 = $urandom_range(8); s.rd2 = $urandom_range(8); end
    s.imm = $urandom; s.pc = $urandom; s.pc4 = $urandom; s.resw = $urandom;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    logic [31:0] a, bf, b, r;
    exm_t nx;
    comb_t c;
    @(negedge clk);
    rst = s.rst;
    ifc.RegWriteE = s.regwrite; ifc.MemWriteE = s.memwrite; ifc.JumpE = s.jump;
    ifc.BranchE = s.branch; ifc.ALUSrcE = s.alusrc; ifc.ResultSrcE = s.resultsrc;
    ifc.ALUControlE = s.op; ifc.RdE = s.rd; ifc.RD1_E = s.rd1; ifc.RD2_E = s.rd2;
    ifc.ImmExtE = s.imm; ifc.PCE = s.pc; ifc.PCPlus4E = s.pc4;
    ifc.ForwardAE = s.fa; ifc.ForwardBE = s.fb; ifc.ResultW = s.resw;
    ifc.StallM = s.stall; ifc.FlushM = s.flush;
    if (s.rst) m = '{default: '0};
    #1;
    a  = pick(s.fa, s.rd1, s.resw, m.alu);
    bf = pick(s.fb, s.rd2, s.resw, m.alu);
    b  = s.alusrc ? s.imm : bf;
    r  = alu_ref(s.op, a, b);
    c.pcsrc  = (s.branch && (r == 32'd0)) || s.jump;
    c.target = s.pc + s.imm;
    comb_q.push_back(c);
    -> comb_ev;
    if (s.rst || s.flush) nx = '{default: '0};
    else if (s.stall) nx = m;
    else nx = '{regwrite: s.regwrite, memwrite: s.memwrite, resultsrc: s.resultsrc,
                rd: s.rd, alu: r, wd: bf, pc4: s.pc4};
    reg_q.push_back(nx);
    m = nx;
    @(posedge clk);
  endtask

  initial begin : comb_monitor
    comb_t e;
    forever begin
      @(comb_ev);
      if (comb_q.size() > 0) begin
        e = comb_q.pop_front();
        chk("PCSrcE", 32'(ifc.PCSrcE), 32'(e.pcsrc));
        chk("PCTargetE", ifc.PCTargetE, e.target);
      end
    end
  end

  initial begin : reg_monitor
    exm_t e;
    forever begin
      @(posedge clk);
      #1;
      if (reg_q.size() > 0) begin
        e = reg_q.pop_front();
        chk("RegWriteM", 32'(ifc.RegWriteM), 32'(e.regwrite));
        chk("MemWriteM", 32'(ifc.MemWriteM), 32'(e.memwrite));
        chk("ResultSrcM", 32'(ifc.ResultSrcM), 32'(e.resultsrc));
        chk("RdM", 32'(ifc.RdM), 32'(e.rd));
        chk("ALUResultM", ifc.ALUResultM, e.alu);
        chk("WriteDataM", ifc.WriteDataM, e.wd);
        chk("PCPlus4M", ifc.PCPlus4M, e.pc4);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    stim_t s;
    m = '{default: '0};
    s = idle();
    s.rst = 1'b1;
    apply(s);
    apply(s);
    #2;
    chk("reset RegWriteM", 32'(ifc.RegWriteM), 32'd0);
    chk("reset ALUResultM", ifc.ALUResultM, 32'd0);
    chk("reset PCPlus4M", ifc.PCPlus4M, 32'd0);

    // add
    s = idle(); s.rd1 = 32'd5; s.rd2 = 32'd7; s.rd = 5'd3; s.regwrite = 1'b1;
    apply(s); #2;
    chk("add ALUResultM", ifc.ALUResultM, 32'd12);
    chk("add RdM", 32'(ifc.RdM), 32'd3);
    chk("add RegWriteM", 32'(ifc.RegWriteM), 32'd1);

    // beq taken
    s = idle(); s.rd1 = 32'h10; s.rd2 = 32'h10; s.op = 3'd1; s.branch = 1'b1;
    s.pc = 32'h100; s.imm = 32'hFFFF_FFF8;
    apply(s); #2;
    chk("beq PCSrcE", 32'(ifc.PCSrcE), 32'd1);
    chk("beq PCTargetE", ifc.PCTargetE, 32'h0000_00F8);

    // forwarding
    s = idle(); s.rd1 = 32'h18; s.rd2 = 32'h8;
    apply(s); #2;
    chk("fwd setup ALUResultM", ifc.ALUResultM, 32'h20);
    s = idle(); s.rd1 = 32'hDEAD_0000; s.rd2 = 32'h0000_BEEF;
    s.fa = 2'b10; s.fb = 2'b01; s.resw = 32'h30;
    apply(s); #2;
    chk("fwd ALUResultM", ifc.ALUResultM, 32'h50);
    chk("fwd WriteDataM", ifc.WriteDataM, 32'h30);

    // signed slt and add overflow wrap
    s = idle(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.op = 3'b101;
    apply(s); #2;
    chk("slt ALUResultM", ifc.ALUResultM, 32'd1);
    s = idle(); s.rd1 = 32'h7FFF_FFFF; s.rd2 = 32'd1;
    apply(s); #2;
    chk("ovf ALUResultM", ifc.ALUResultM, 32'h8000_0000);

    // stall for three edges, then stall+flush
    s = idle(); s.rd1 = 32'h11; s.rd2 = 32'h22; s.rd = 5'd9;
    s.regwrite = 1'b1; s.memwrite = 1'b1; s.resultsrc = 2'b10;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rand_stim(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b0;
      apply(s);
    end
    #2;
    chk("stall ALUResultM", ifc.ALUResultM, 32'h33);
    chk("stall RdM", 32'(ifc.RdM), 32'd9);
    s = rand_stim(); s.rst = 1'b0; s.stall = 1'b1; s.flush = 1'b1;
    apply(s); #2;
    chk("flush RegWriteM", 32'(ifc.RegWriteM), 32'd0);
    chk("flush MemWriteM", 32'(ifc.MemWriteM), 32'd0);
    chk("flush RdM", 32'(ifc.RdM), 32'd0);

    // async reset asserted mid-stall, between edges
    s = idle(); s.rd1 = 32'h40; s.rd = 5'd5; s.regwrite = 1'b1; s.pc4 = 32'h44;
    apply(s);
    s.stall = 1'b1;
    apply(s);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async RegWriteM", 32'(ifc.RegWriteM), 32'd0);
    chk("async RdM", 32'(ifc.RdM), 32'd0);
    chk("async ALUResultM", ifc.ALUResultM, 32'd0);
    chk("async PCPlus4M", ifc.PCPlus4M, 32'd0);
    m = '{default: '0};
    s = idle(); s.rst = 1'b1; s.stall = 1'b1;
    apply(s);
    s = idle(); s.rd1 = 32'h7; s.rd = 5'd12; s.regwrite = 1'b1; s.stall = 1'b0;
    apply(s); #2;
    chk("post-reset RdM", 32'(ifc.RdM), 32'd12);
    chk("post-reset ALUResultM", ifc.ALUResultM, 32'd7);

    for (int i = 0; i < 400; i++) apply(rand_stim());

    repeat (3) @(negedge clk);
    chk("scoreboard drained", 32'(reg_q.size() + comb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
